// File: rtl/chacha_qr_hex_display_pkg.sv
// Shared constants and helpers for the ChaCha quarter-round hex display tile:
// seed words, per-step rotate amounts, rotate and hex-to-7-segment functions.
package chacha_qr_hex_display_pkg;

  localparam logic [31:0] SEED_A = 32'h11111111;
  localparam logic [31:0] SEED_B = 32'h01020304;
  localparam logic [31:0] SEED_C = 32'h9b8d6f43;
  localparam logic [31:0] SEED_D = 32'h01234567;

  localparam logic [4:0] ROT_AMT [4] = '{5'd16, 5'd12, 5'd8, 5'd7};

  // amt is never 0 here, so the right shift by (32 - amt) stays in range
  function automatic logic [31:0] rotl32(input logic [31:0] x, input logic [4:0] amt);
    logic [5:0] rsh;
    rsh = 6'd32 - {1'b0, amt};
    return (x << amt) | (x >> rsh);
  endfunction

  function automatic logic [6:0] hex_to_seg(input logic [3:0] hex);
    logic [6:0] seg;
    case (hex)
      4'h0: seg = 7'h3F;
      4'h1: seg = 7'h06;
      4'h2: seg = 7'h5B;
      4'h3: seg = 7'h4F;
      4'h4: seg = 7'h66;
      4'h5: seg = 7'h6D;
      4'h6: seg = 7'h7D;
      4'h7: seg = 7'h07;
      4'h8: seg = 7'h7F;
      4'h9: seg = 7'h6F;
      4'hA: seg = 7'h77;
      4'hB: seg = 7'h7C;
      4'hC: seg = 7'h39;
      4'hD: seg = 7'h5E;
      4'hE: seg = 7'h79;
      default: seg = 7'h71;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/chacha_qr_hex_display_hex7seg.sv
// Combinational hex digit to 7-segment glyph decoder, segments {g,f,e,d,c,b,a}.
module chacha_qr_hex_display_hex7seg
  import chacha_qr_hex_display_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  assign seg = hex_to_seg(hex);

endmodule

// File: rtl/chacha_qr_hex_display.sv
// ChaCha20 quarter-round engine whose word 'a' is shown nibble by nibble on a
// 7-segment display; one chained quarter round runs after every full word shown.
module chacha_qr_hex_display
  import chacha_qr_hex_display_pkg::*;
#(
  parameter int MAX_COUNT = 1000
) (
  input  logic [7:0] io_in,
  output logic [7:0] io_out
);

  localparam int CW = (MAX_COUNT > 1) ? $clog2(MAX_COUNT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(MAX_COUNT - 1);

  logic clk;
  logic rst_n;
  logic unused_io;

  assign clk       = io_in[0];
  assign rst_n     = io_in[1];
  assign unused_io = ^io_in[7:2];

  logic [CW-1:0] cnt_reg;
  logic [2:0]    nib_idx_reg;
  logic          qr_busy_reg;
  logic [1:0]    qr_step_reg;
  logic [31:0]   a_reg, b_reg, c_reg, d_reg;
  logic [31:0]   disp_word_reg;
  logic          tick;

  assign tick = (cnt_reg == CNT_LAST);

  // Shared ARX lane: even steps work on (a,b,d), odd steps on (c,d,b)
  logic [31:0] arx_x, arx_y, arx_z;
  logic [31:0] sum_next;
  logic [31:0] rot_next;

  always_comb begin
    arx_x = a_reg;
    arx_y = b_reg;
    arx_z = d_reg;
    if (qr_step_reg[0]) begin
      arx_x = c_reg;
      arx_y = d_reg;
      arx_z = b_reg;
    end
    sum_next = arx_x + arx_y;
    rot_next = rotl32(arx_z ^ sum_next, ROT_AMT[qr_step_reg]);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_reg       <= '0;
      nib_idx_reg   <= 3'd0;
      qr_busy_reg   <= 1'b0;
      qr_step_reg   <= 2'd0;
      a_reg         <= SEED_A;
      b_reg         <= SEED_B;
      c_reg         <= SEED_C;
      d_reg         <= SEED_D;
      disp_word_reg <= SEED_A;
    end else begin
      cnt_reg <= tick ? '0 : cnt_reg + 1'b1;

      if (qr_busy_reg) begin
        if (qr_step_reg[0]) begin
          c_reg <= sum_next;
          b_reg <= rot_next;
        end else begin
          a_reg <= sum_next;
          d_reg <= rot_next;
        end
        qr_step_reg <= qr_step_reg + 2'd1;
        // Step 3 only touches c and b, so a_reg already holds the final a
        if (qr_step_reg == 2'd3) begin
          qr_busy_reg   <= 1'b0;
          disp_word_reg <= a_reg;
        end
      end

      if (tick) begin
        if (nib_idx_reg != 3'd7) begin
          nib_idx_reg <= nib_idx_reg + 3'd1;
        end else begin
          nib_idx_reg <= 3'd0;
          qr_busy_reg <= 1'b1;
          qr_step_reg <= 2'd0;
        end
      end
    end
  end

  // ~nib_idx == 7 - nib_idx, so this picks the MSB nibble first
  logic [3:0] cur_nibble;
  logic [6:0] cur_seg;

  assign cur_nibble = disp_word_reg[{~nib_idx_reg, 2'b00} +: 4];

  chacha_qr_hex_display_hex7seg u_hex7seg (
    .hex (cur_nibble),
    .seg (cur_seg)
  );

  assign io_out = {(nib_idx_reg == 3'd0), cur_seg};

endmodule

// File: tb/tb_chacha_qr_hex_display.sv
// Randomized-unused-input bench for chacha_qr_hex_display with a cycle-level
// behavioural model (whole quarter round computed at once) and literal pins.
module tb_chacha_qr_hex_display;

  localparam int MC = 100;

  logic       clk;
  logic       rst_n;
  logic [5:0] junk;
  logic [7:0] io_in;
  logic [7:0] io_out;

  assign io_in = {junk, rst_n, clk};

  chacha_qr_hex_display #(.MAX_COUNT(MC)) dut (
    .io_in  (io_in),
    .io_out (io_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [6:0] glyph [0:15] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  // model state
  int          m_cnt;
  int          m_nib;
  int          m_busy_left;
  logic [31:0] m_a, m_b, m_c, m_d, m_word;

  function automatic logic [31:0] rl(input logic [31:0] x, input int n);
    return (x << n) | (x >> (32 - n));
  endfunction

  task automatic quarter_round();
    m_a = m_a + m_b; m_d = rl(m_d ^ m_a, 16);
    m_c = m_c + m_d; m_b = rl(m_b ^ m_c, 12);
    m_a = m_a + m_b; m_d = rl(m_d ^ m_a, 8);
    m_c = m_c + m_d; m_b = rl(m_b ^ m_c, 7);
  endtask

  task automatic model_edge(input logic r);
    if (!r) begin
      m_a = 32'h11111111; m_b = 32'h01020304; m_c = 32'h9b8d6f43; m_d = 32'h01234567;
      m_word = 32'h11111111; m_cnt = 0; m_nib = 0; m_busy_left = 0;
    end else begin
      if (m_busy_left > 0) begin
        m_busy_left--;
        if (m_busy_left == 0) begin
          quarter_round();
          m_word = m_a;
        end
      end
      if (m_cnt == MC - 1) begin
        m_cnt = 0;
        if (m_nib < 7) m_nib++;
        else begin
          m_nib = 0;
          m_busy_left = 4;
        end
      end else begin
        m_cnt++;
      end
    end
  endtask

  function automatic logic [7:0] model_out();
    logic [3:0] nib;
    nib = 4'((m_word >> (28 - 4 * m_nib)) & 32'hF);
    return {(m_nib == 0), glyph[nib]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  // one clock: model follows the edge, outputs compared on the falling edge
  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      model_edge(rst_n);
      @(negedge clk);
      check("cycle_out", {24'd0, io_out}, {24'd0, model_out()});
      junk = 6'($urandom);
    end
  endtask

  logic [7:0] seq_exp [0:6] = '{8'h77, 8'h5B, 8'h77, 8'h6F, 8'h5B, 8'h71, 8'h66};

  task automatic check_round_done(input string tag);
    check({tag, "_out"},   {24'd0, io_out}, 32'h000000F9);
    check({tag, "_dut_a"}, dut.a_reg, 32'hea2a92f4);
    check({tag, "_dut_b"}, dut.b_reg, 32'hcb1cf8ce);
    check({tag, "_dut_c"}, dut.c_reg, 32'h4581472e);
    check({tag, "_dut_d"}, dut.d_reg, 32'h5881c4bb);
    check({tag, "_mdl_a"}, m_a, 32'hea2a92f4);
    check({tag, "_mdl_b"}, m_b, 32'hcb1cf8ce);
  endtask

  initial begin
    rst_n = 1'b0;
    junk  = 6'($urandom);
    m_cnt = 0; m_nib = 0; m_busy_left = 0;
    m_a = '0; m_b = '0; m_c = '0; m_d = '0; m_word = '0;
    @(negedge clk);

    // scenario 1/2: reset value, held for 99 clocks, first tick on the 100th
    cyc(3);
    check("reset_out", {24'd0, io_out}, 32'h86);
    rst_n = 1'b1;
    cyc(99);
    check("pre_tick_out", {24'd0, io_out}, 32'h86);
    cyc(1);
    check("tick1_out", {24'd0, io_out}, 32'h06);
    cyc(6 * MC);
    check("tick7_out", {24'd0, io_out}, 32'h06);

    // scenario 3: eighth tick, old word kept through the round
    cyc(MC);
    check("tick8_out", {24'd0, io_out}, 32'h86);
    cyc(3);
    check("busy_out", {24'd0, io_out}, 32'h86);
    cyc(1);
    check_round_done("round1");

    // scenario 4: remaining nibbles of the new word
    for (int k = 0; k < 7; k++) begin
      cyc(MC);
      check($sformatf("nib%0d_out", k + 1), {24'd0, io_out}, {24'd0, seq_exp[k]});
    end

    // scenario 5: second round starts, reset lands on the step-2 clock
    cyc(MC);
    cyc(2);
    rst_n = 1'b0;
    cyc(1);
    check("midrst_out", {24'd0, io_out}, 32'h86);
    check("midrst_a", dut.a_reg, 32'h11111111);
    check("midrst_d", dut.d_reg, 32'h01234567);
    rst_n = 1'b1;
    cyc(8 * MC + 3);
    check("rerun_busy_out", {24'd0, io_out}, 32'h86);
    cyc(1);
    check_round_done("round1_again");
    cyc(2 * MC);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
